// File: rtl/kros_pkg.sv
// Shared definitions for the pattern sequencer: default ROM geometry and FSM state type.
package kros_pkg;

    localparam int NUM_SEQ_DEF = 64;
    localparam int SEQ_LEN_DEF = 16;
    localparam int SEQ_W       = $clog2(NUM_SEQ_DEF);
    localparam int STEP_W      = $clog2(SEQ_LEN_DEF);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        SWITCH
    } seq_state_t;

endpackage

// File: rtl/tick_sync.sv
// Brings an asynchronous level (e.g. the throttle's slow_clk) into clk_50 and emits a
// one-cycle pulse on each rising edge: 2-flop synchronizer (s1, s2) plus edge register s3.
module tick_sync (
    input  logic clk_50,
    input  logic reset,
    input  logic async_in,
    output logic tick
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic s3_q, s3_d;

    always_comb begin
        s1_d = async_in;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    always_ff @(posedge clk_50) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign tick = s2_q & ~s3_q;

endmodule

// File: rtl/seq_addr_gen.sv
// Pattern sequencer driving the pattern ROM read address {seq_num, step} from slow_clk ticks
// and the sequence buttons. Optional SEQ_ADDR_GEN_PAUSE_EN adds a pb_pause toggle that freezes stepping.
module seq_addr_gen
    import kros_pkg::*;
#(
    parameter int NUM_SEQ = NUM_SEQ_DEF,
    parameter int SEQ_LEN = SEQ_LEN_DEF,
    parameter int ADDR_W  = SEQ_W + STEP_W
) (
    input  logic                       clk_50,
    input  logic                       reset,
    input  logic                       slow_clk,
    input  logic                       pb_seq_up,
    input  logic                       pb_seq_dn,
`ifdef SEQ_ADDR_GEN_PAUSE_EN
    input  logic                       pb_pause,
`endif
    output logic [ADDR_W-1:0]          rom_addr,
    output logic [$clog2(NUM_SEQ)-1:0] seq_num,
    output logic [$clog2(SEQ_LEN)-1:0] step,
    output logic                       seq_wrap
);

    localparam int SB = $clog2(NUM_SEQ);
    localparam int TB = $clog2(SEQ_LEN);

    logic          tick_raw;
    logic          tick;
    logic          up_q, up_d, dn_q, dn_d;
    logic          up_edge, dn_edge;
    logic [SB-1:0] pending_q, pending_d;
    logic [SB-1:0] seq_q, seq_d;
    logic [TB-1:0] step_q, step_d;
    logic          wrap_q, wrap_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    seq_state_t    state_q, state_d;

    tick_sync u_tick_sync (
        .clk_50   (clk_50),
        .reset    (reset),
        .async_in (slow_clk),
        .tick     (tick_raw)
    );

`ifdef SEQ_ADDR_GEN_PAUSE_EN
    logic pause_q, pause_d, paused_q, paused_d;

    always_comb begin
        pause_d  = pb_pause;
        paused_d = paused_q ^ (pb_pause & ~pause_q);
    end

    always_ff @(posedge clk_50) begin
        if (reset) begin
            pause_q  <= 1'b0;
            paused_q <= 1'b0;
        end else begin
            pause_q  <= pause_d;
            paused_q <= paused_d;
        end
    end

    // Paused ticks are swallowed here so both step advance and pending switches wait.
    assign tick = tick_raw & ~paused_q;
`else
    assign tick = tick_raw;
`endif

    always_comb begin
        up_d      = pb_seq_up;
        dn_d      = pb_seq_dn;
        up_edge   = pb_seq_up & ~up_q;
        dn_edge   = pb_seq_dn & ~dn_q;
        pending_d = pending_q;
        if (up_edge && !dn_edge) begin
            pending_d = pending_q + SB'(1);
        end else if (dn_edge && !up_edge) begin
            pending_d = pending_q - SB'(1);
        end

        state_d = state_q;
        seq_d   = seq_q;
        step_d  = step_q;
        wrap_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = RUN;
                    step_d  = '0;
                end
            end
            RUN: begin
                if (pending_q != seq_q) begin
                    state_d = SWITCH;
                end else if (tick) begin
                    step_d = step_q + TB'(1);
                    wrap_d = (step_q == TB'(SEQ_LEN - 1));
                end
            end
            SWITCH: begin
                // A request cancelled before the tick leaves the sequence playing undisturbed.
                if (pending_q == seq_q) begin
                    state_d = RUN;
                    if (tick) begin
                        step_d = step_q + TB'(1);
                        wrap_d = (step_q == TB'(SEQ_LEN - 1));
                    end
                end else if (tick) begin
                    state_d = RUN;
                    seq_d   = pending_q;
                    step_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        addr_d = {seq_d, step_d};
    end

    always_ff @(posedge clk_50) begin
        if (reset) begin
            up_q      <= 1'b0;
            dn_q      <= 1'b0;
            pending_q <= '0;
            seq_q     <= '0;
            step_q    <= '0;
            wrap_q    <= 1'b0;
            addr_q    <= '0;
            state_q   <= IDLE;
        end else begin
            up_q      <= up_d;
            dn_q      <= dn_d;
            pending_q <= pending_d;
            seq_q     <= seq_d;
            step_q    <= step_d;
            wrap_q    <= wrap_d;
            addr_q    <= addr_d;
            state_q   <= state_d;
        end
    end

    assign rom_addr = addr_q;
    assign seq_num  = seq_q;
    assign step     = step_q;
    assign seq_wrap = wrap_q;

endmodule

// File: doc/seq_addr_gen.md
Name: seq_addr_gen

Overview:
- Pattern sequencer that sits directly upstream of the dual-port pattern ROM.
- Turns the throttle's slow_clk into step ticks and the debounced sequence buttons into a selected sequence number.
- Drives the ROM read address (seq_num * SEQ_LEN + step) and exports seq_num / step for the HEX display path.
- Replaces the unconnected sequencer stub in the top level.

Parameters:
- NUM_SEQ, 64, number of stored sequences; power of 2.
- SEQ_LEN, 16, steps per sequence; power of 2.
- ADDR_W, 10, ROM address width; must equal log2(NUM_SEQ*SEQ_LEN).

Ports:
- clk_50  input  1  system clock, 50 MHz.
- reset  input  1  synchronous reset, active-high.
- slow_clk  input  1  throttle output; level, asynchronous to this block's sampling.
- pb_seq_up  input  1  debounced level, synchronous to clk_50; rising edge = next sequence.
- pb_seq_dn  input  1  debounced level, synchronous to clk_50; rising edge = previous sequence.
- rom_addr  output  ADDR_W  registered ROM address_b.
- seq_num  output  log2(NUM_SEQ)  currently playing sequence.
- step  output  log2(SEQ_LEN)  current step within the sequence.
- seq_wrap  output  1  one-cycle pulse when step wraps from SEQ_LEN-1 to 0.

Behaviour:
- Clocking and reset:
  - One clock, clk_50. Reset is synchronous and active-high.
  - Reset values: rom_addr=0, seq_num=0, step=0, seq_wrap=0, pending_seq=0, sync/edge registers=0, FSM=IDLE.
- Step tick:
  - slow_clk passes through a 2-flop synchronizer (s1, s2) and an edge register s3.
  - tick = s2 & ~s3.
  - Latency: slow_clk is sampled high at edge E0, so tick is high during the cycle after E1 and the new rom_addr is registered at E2.
- Buttons:
  - Each button has a 1-register rising-edge detector.
  - up edge alone: pending_seq += 1, wrapping NUM_SEQ-1 -> 0.
  - dn edge alone: pending_seq -= 1, wrapping 0 -> NUM_SEQ-1.
  - Both edges in the same cycle: no change.
  - Multiple presses between ticks accumulate in pending_seq.
- FSM states: IDLE, RUN, SWITCH.
  - IDLE: outputs hold at reset values. First tick -> RUN with step=0. This tick does not advance step, so step 0 is presented for a full slow period.
  - RUN, pending_seq != seq_num: go to SWITCH in the same cycle. No output change.
  - RUN, tick: step = (step+1) mod SEQ_LEN. If step was SEQ_LEN-1, pulse seq_wrap for exactly one clk_50 cycle, registered alongside rom_addr.
  - SWITCH: waits for the next tick. On that tick: seq_num=pending_seq, step=0, seq_wrap=0, back to RUN.
  - SWITCH: if pending_seq returns to seq_num before the tick (up then down), return to RUN with no effect and no step reset.
  - Net effect: sequence changes take effect only on a step boundary and always restart at step 0.
- rom_addr:
  - Registered: {seq_num, step} at all times; updates on the same edge as seq_num/step.
  - Widths are exact concatenations, with no overflow handling needed.
- Tick during reset: ignored. After reset deasserts, the sync registers start from 0, so a slow_clk that is already high produces one tick 2 cycles later.
- Reset mid-sequence: everything returns to reset values on the next edge; pending requests are discarded.

Optional Feature:
- Macro: SEQ_ADDR_GEN_PAUSE_EN.
- When defined:
  - Adds input pb_pause (1 bit, debounced level).
  - Each rising edge toggles a paused flag (reset 0).
  - While paused: ticks are ignored (step frozen, no seq_wrap); button requests still accumulate.
  - On unpause, a pending switch is applied at the next tick as normal.
- When undefined: no pb_pause port, and behaviour is exactly as above.

Decomposition:
- Shared package kros_pkg holds:
  - NUM_SEQ_DEF, SEQ_LEN_DEF, and the derived SEQ_W=$clog2 and STEP_W widths.
  - The FSM state typedef seq_state_t {IDLE, RUN, SWITCH}.
- One sub-module: tick_sync (2-flop synchronizer plus rising-edge pulse). It is reusable for slow_clk wherever the codebase consumes the throttle output in the clk_50 domain.

Test Plan:
1. Reset, then 3 slow_clk rising edges -> step 0,1,2; rom_addr 0x000,0x001,0x002. Each change lands 2 edges after the sampling edge.
2. 16 ticks from step 0 -> step wraps 15->0, seq_wrap high for exactly 1 cycle, rom_addr 0x00F->0x000.
3. At step 5 of seq 0, pulse pb_seq_up twice, then tick -> seq_num=2, step=0, rom_addr=0x020. No step 6 appears.
4. seq 0, pb_seq_dn once, tick -> seq_num=63, rom_addr=0x3F0. Then pb_seq_up once, tick -> seq_num=0.
5. pb_seq_up and pb_seq_dn rise in the same cycle, then tick -> seq_num unchanged, step increments normally. Separately: up then dn before a tick -> no switch, step continues.
6. Assert reset at step 9 of seq 4 with an up request pending -> next edge: rom_addr=0, seq_num=0, FSM IDLE. The first tick after release yields step 0, not step 1.
